// File: rtl/bp_l15_arb_pkg.sv
// Shared definitions for the L1.5 request arbiter.
//   arb_state_e : main arbiter FSM states
//   *_RET/ST_ACK: L1.5 return-type encodings the arbiter decodes
//   safe_clog2  : index width that never collapses to zero bits
package bp_l15_arb_pkg;

  typedef enum logic [1:0] {
    e_idle      = 2'd0,
    e_send      = 2'd1,
    e_wait_resp = 2'd2
  } arb_state_e;

  localparam logic [3:0] LOAD_RET = 4'b0000;
  localparam logic [3:0] ST_ACK   = 4'b0100;
  localparam logic [3:0] INT_RET  = 4'b0111;

  function automatic logic is_int_ret(input logic [3:0] rt);
    return rt == INT_RET;
  endfunction

  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bp_l15_rr_arb.sv
// Pointer-based round-robin arbiter.
//   clk_i, reset_n_i : clock, async active-low reset
//   reqs_i           : per-requester request
//   grants_o         : one-hot winner (combinational)
//   sel_idx_o        : index of the winner
//   v_o              : some request is present
//   yumi_i           : winner taken; pointer moves to the winner
// Priority starts at pointer+1 and wraps; pointer resets to num_req_p-1
// so requester 0 wins first.
module bp_l15_rr_arb
  import bp_l15_arb_pkg::*;
#(
  parameter int num_req_p = 2,
  localparam int ptr_w_lp = safe_clog2(num_req_p)
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic [num_req_p-1:0] reqs_i,
  output logic [num_req_p-1:0] grants_o,
  output logic [ptr_w_lp-1:0]  sel_idx_o,
  output logic                 v_o,
  input  logic                 yumi_i
);

  logic [ptr_w_lp-1:0]    r_ptr;
  logic [ptr_w_lp:0]      w_inc;
  logic [ptr_w_lp:0]      w_start;
  logic [ptr_w_lp:0]      w_sum;
  logic [2*num_req_p-1:0] w_dbl;
  logic [num_req_p-1:0]   w_rot;
  logic [ptr_w_lp-1:0]    w_off;

  assign w_inc   = {1'b0, r_ptr} + (ptr_w_lp+1)'(1);
  assign w_start = (w_inc == (ptr_w_lp+1)'(num_req_p)) ? '0 : w_inc;

  // Rotate so bit 0 is the highest-priority requester.
  assign w_dbl = {reqs_i, reqs_i};
  assign w_rot = w_dbl[w_start +: num_req_p];

  always_comb begin
    v_o   = 1'b0;
    w_off = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (!v_o && w_rot[i]) begin
        v_o   = 1'b1;
        w_off = ptr_w_lp'(i);
      end
    end
  end

  assign w_sum     = w_start + {1'b0, w_off};
  assign sel_idx_o = (w_sum >= (ptr_w_lp+1)'(num_req_p))
                     ? ptr_w_lp'(w_sum - (ptr_w_lp+1)'(num_req_p))
                     : ptr_w_lp'(w_sum);

  always_comb begin
    grants_o = '0;
    for (int j = 0; j < num_req_p; j++) begin
      grants_o[j] = v_o && (sel_idx_o == ptr_w_lp'(j));
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_ptr <= ptr_w_lp'(num_req_p - 1);
    end else if (yumi_i && v_o) begin
      r_ptr <= sel_idx_o;
    end
  end

endmodule

// File: rtl/bp_l15_req_arbiter.sv
// Shares one L1.5 transducer request/return port among num_req_p
// BlackParrot transducers.
//   clk_i, reset_n_i        : clock, async active-low reset
//   req_*_i / req_ack_o     : flattened per-requester request fields, one-hot accept
//   resp_val_o / resp_ack_i : per-requester return handshake
//   resp_returntype_o, resp_data_{0,1}_o : shared return payload
//   transducer_l15_*        : request to L1.5, and transducer_l15_req_ack return consume
//   l15_transducer_*        : L1.5 request accept and return
//   timeout_o               : sticky, owner's return overdue
//   stray_o                 : pulse, unowned non-INT return dropped
// State table:
//   e_idle      | no owner; arbitrate among req_val_i
//   e_send      | owner's request presented to L1.5 until accepted
//   e_wait_resp | waiting for the owner's single return
// INT_RET is broadcast to every requester and overrides routing in any
// state; the FSM holds (SEND may still complete its request).
module bp_l15_req_arbiter
  import bp_l15_arb_pkg::*;
#(
  parameter int num_req_p        = 2,
  parameter int timeout_cycles_p = 1024,
  localparam int ptr_w_lp = safe_clog2(num_req_p),
  localparam int cnt_w_lp = $clog2(timeout_cycles_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [num_req_p-1:0]    req_val_i,
  input  logic [num_req_p*5-1:0]  req_rqtype_i,
  input  logic [num_req_p-1:0]    req_nc_i,
  input  logic [num_req_p*3-1:0]  req_size_i,
  input  logic [num_req_p*40-1:0] req_address_i,
  input  logic [num_req_p*64-1:0] req_data_i,
  input  logic [num_req_p*2-1:0]  req_l1rplway_i,
  output logic [num_req_p-1:0]    req_ack_o,
  output logic [num_req_p-1:0]    resp_val_o,
  output logic [3:0]              resp_returntype_o,
  output logic [63:0]             resp_data_0_o,
  output logic [63:0]             resp_data_1_o,
  input  logic [num_req_p-1:0]    resp_ack_i,
  output logic [4:0]              transducer_l15_rqtype,
  output logic                    transducer_l15_nc,
  output logic [2:0]              transducer_l15_size,
  output logic                    transducer_l15_val,
  output logic [39:0]             transducer_l15_address,
  output logic [63:0]             transducer_l15_data,
  output logic [1:0]              transducer_l15_l1rplway,
  input  logic                    l15_transducer_ack,
  input  logic                    l15_transducer_val,
  input  logic [3:0]              l15_transducer_returntype,
  input  logic [63:0]             l15_transducer_data_0,
  input  logic [63:0]             l15_transducer_data_1,
  output logic                    transducer_l15_req_ack,
  output logic                    timeout_o,
  output logic                    stray_o
);

  arb_state_e           r_state, w_state_nxt;
  logic [ptr_w_lp-1:0]  r_grant;
  logic [num_req_p-1:0] r_grant_oh;
  logic [num_req_p-1:0] r_bcast_mask;
  logic [cnt_w_lp-1:0]  r_cnt;
  logic                 r_timeout;

  logic [num_req_p-1:0] w_arb_grants;
  logic [ptr_w_lp-1:0]  w_arb_idx;
  logic                 w_arb_v;
  logic                 w_arb_yumi;
  logic                 w_int_ret;
  logic                 w_other_ret;
  logic                 w_owner_ack;
  logic [num_req_p-1:0] w_bcast_acked;
  logic                 w_bcast_done;

  bp_l15_rr_arb #(.num_req_p(num_req_p)) u_rr (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .reqs_i    (req_val_i),
    .grants_o  (w_arb_grants),
    .sel_idx_o (w_arb_idx),
    .v_o       (w_arb_v),
    .yumi_i    (w_arb_yumi)
  );

  assign w_int_ret     = l15_transducer_val && is_int_ret(l15_transducer_returntype);
  assign w_other_ret   = l15_transducer_val && !is_int_ret(l15_transducer_returntype);
  assign w_owner_ack   = |(resp_ack_i & r_grant_oh);
  // Acks from requesters already served are harmless: OR keeps them set.
  assign w_bcast_acked = r_bcast_mask | resp_ack_i;
  assign w_bcast_done  = w_int_ret && (&w_bcast_acked);
  assign timeout_o     = r_timeout;

  always_comb begin
    w_state_nxt             = r_state;
    w_arb_yumi              = 1'b0;
    req_ack_o               = '0;
    resp_val_o              = '0;
    resp_returntype_o       = l15_transducer_returntype;
    resp_data_0_o           = l15_transducer_data_0;
    resp_data_1_o           = l15_transducer_data_1;
    transducer_l15_rqtype   = '0;
    transducer_l15_nc       = 1'b0;
    transducer_l15_size     = '0;
    transducer_l15_val      = 1'b0;
    transducer_l15_address  = '0;
    transducer_l15_data     = '0;
    transducer_l15_l1rplway = '0;
    transducer_l15_req_ack  = 1'b0;
    stray_o                 = 1'b0;

    case (r_state)
      e_idle: begin
        if (w_arb_v && !w_int_ret) begin
          w_arb_yumi  = 1'b1;
          w_state_nxt = e_send;
        end
        if (w_other_ret) begin
          transducer_l15_req_ack = 1'b1;
          stray_o                = 1'b1;
        end
      end
      e_send: begin
        transducer_l15_val      = 1'b1;
        transducer_l15_rqtype   = req_rqtype_i[r_grant*5 +: 5];
        transducer_l15_nc       = req_nc_i[r_grant];
        transducer_l15_size     = req_size_i[r_grant*3 +: 3];
        transducer_l15_address  = req_address_i[r_grant*40 +: 40];
        transducer_l15_data     = req_data_i[r_grant*64 +: 64];
        transducer_l15_l1rplway = req_l1rplway_i[r_grant*2 +: 2];
        req_ack_o               = r_grant_oh & {num_req_p{l15_transducer_ack}};
        if (l15_transducer_ack) begin
          w_state_nxt = e_wait_resp;
        end
        if (w_other_ret) begin
          transducer_l15_req_ack = 1'b1;
          stray_o                = 1'b1;
        end
      end
      e_wait_resp: begin
        if (w_other_ret) begin
          resp_val_o             = r_grant_oh;
          transducer_l15_req_ack = w_owner_ack;
          if (w_owner_ack) begin
            w_state_nxt = e_idle;
          end
        end
      end
      default: w_state_nxt = e_idle;
    endcase

    if (w_int_ret) begin
      resp_val_o             = ~r_bcast_mask;
      transducer_l15_req_ack = w_bcast_done;
    end

    // Outputs are forced low for the whole reset interval, including the
    // asynchronous assertion edge before any clock arrives.
    if (!reset_n_i) begin
      w_state_nxt             = e_idle;
      w_arb_yumi              = 1'b0;
      req_ack_o               = '0;
      resp_val_o              = '0;
      resp_returntype_o       = '0;
      resp_data_0_o           = '0;
      resp_data_1_o           = '0;
      transducer_l15_rqtype   = '0;
      transducer_l15_nc       = 1'b0;
      transducer_l15_size     = '0;
      transducer_l15_val      = 1'b0;
      transducer_l15_address  = '0;
      transducer_l15_data     = '0;
      transducer_l15_l1rplway = '0;
      transducer_l15_req_ack  = 1'b0;
      stray_o                 = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state      <= e_idle;
      r_grant      <= '0;
      r_grant_oh   <= '0;
      r_bcast_mask <= '0;
      r_cnt        <= '0;
      r_timeout    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_arb_yumi) begin
        r_grant    <= w_arb_idx;
        r_grant_oh <= w_arb_grants;
      end
      if (w_int_ret) begin
        r_bcast_mask <= w_bcast_done ? '0 : w_bcast_acked;
      end
      if (r_state == e_wait_resp && w_state_nxt == e_wait_resp) begin
        if (r_cnt != cnt_w_lp'(timeout_cycles_p)) begin
          r_cnt <= r_cnt + cnt_w_lp'(1);
        end
      end else begin
        r_cnt <= '0;
      end
      // This WAIT_RESP cycle is the timeout_cycles_p-th one.
      if (r_state == e_wait_resp && r_cnt == cnt_w_lp'(timeout_cycles_p - 1)) begin
        r_timeout <= 1'b1;
      end
    end
  end

  a_req_held_in_send: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (r_state == e_send) |-> |(req_val_i & r_grant_oh));

endmodule

// File: tb/tb_bp_l15_req_arbiter.sv
module tb_bp_l15_req_arbiter;
  import bp_l15_arb_pkg::*;

  localparam int N = 2;
  localparam int T = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  req_val;
  logic [N*5-1:0]  req_rqtype;
  logic [N-1:0]    req_nc;
  logic [N*3-1:0]  req_size;
  logic [N*40-1:0] req_address;
  logic [N*64-1:0] req_data;
  logic [N*2-1:0]  req_l1rplway;
  logic [N-1:0]  req_ack_o;
  logic [N-1:0]  resp_val_o;
  logic [3:0]    resp_returntype_o;
  logic [63:0]   resp_data_0_o, resp_data_1_o;
  logic [N-1:0]  resp_ack;
  logic [4:0]    transducer_l15_rqtype;
  logic          transducer_l15_nc;
  logic [2:0]    transducer_l15_size;
  logic          transducer_l15_val;
  logic [39:0]   transducer_l15_address;
  logic [63:0]   transducer_l15_data;
  logic [1:0]    transducer_l15_l1rplway;
  logic          l15_ack, l15_val;
  logic [3:0]    l15_rt;
  logic [63:0]   l15_d0, l15_d1;
  logic          transducer_l15_req_ack;
  logic          timeout_o, stray_o;

  int total = 0;
  int bad   = 0;
  int last_g;   // reference model: most recent grant, N-1 after reset

  always #5 clk = ~clk;

  bp_l15_req_arbiter #(.num_req_p(N), .timeout_cycles_p(T)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .req_val_i(req_val), .req_rqtype_i(req_rqtype), .req_nc_i(req_nc),
    .req_size_i(req_size), .req_address_i(req_address), .req_data_i(req_data),
    .req_l1rplway_i(req_l1rplway), .req_ack_o(req_ack_o),
    .resp_val_o(resp_val_o), .resp_returntype_o(resp_returntype_o),
    .resp_data_0_o(resp_data_0_o), .resp_data_1_o(resp_data_1_o),
    .resp_ack_i(resp_ack),
    .transducer_l15_rqtype(transducer_l15_rqtype), .transducer_l15_nc(transducer_l15_nc),
    .transducer_l15_size(transducer_l15_size), .transducer_l15_val(transducer_l15_val),
    .transducer_l15_address(transducer_l15_address), .transducer_l15_data(transducer_l15_data),
    .transducer_l15_l1rplway(transducer_l15_l1rplway),
    .l15_transducer_ack(l15_ack), .l15_transducer_val(l15_val),
    .l15_transducer_returntype(l15_rt), .l15_transducer_data_0(l15_d0),
    .l15_transducer_data_1(l15_d1), .transducer_l15_req_ack(transducer_l15_req_ack),
    .timeout_o(timeout_o), .stray_o(stray_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round robin: scan from the requester after the last one served.
  function automatic int model_pick(input logic [N-1:0] rv);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last_g + k) % N;
      if (rv[c]) return c;
    end
    return -1;
  endfunction

  task automatic new_fields(input int r);
    req_rqtype[r*5 +: 5]    = 5'($urandom);
    req_nc[r]               = 1'($urandom);
    req_size[r*3 +: 3]      = 3'($urandom);
    req_address[r*40 +: 40] = {8'(r), 32'($urandom)};
    req_data[r*64 +: 64]    = {32'($urandom), 32'($urandom)};
    req_l1rplway[r*2 +: 2]  = 2'($urandom);
  endtask

  task automatic grant_only(output int g);
    int n;
    n = 0;
    g = model_pick(req_val);
    while (transducer_l15_val !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk("l15_val_rise", transducer_l15_val, 1'b1);
    if (g >= 0) begin
      chk("l15_addr", transducer_l15_address, req_address[g*40 +: 40]);
      chk("l15_data", transducer_l15_data, req_data[g*64 +: 64]);
      chk("l15_fields", {transducer_l15_rqtype, transducer_l15_nc, transducer_l15_size,
                         transducer_l15_l1rplway},
          {req_rqtype[g*5 +: 5], req_nc[g], req_size[g*3 +: 3], req_l1rplway[g*2 +: 2]});
      last_g = g;
    end
    l15_ack = 1'b1;
    #1;
    chk("req_ack", req_ack_o, (g >= 0) ? (1 << g) : 0);
    tick();
    l15_ack = 1'b0;
  endtask

  task automatic ret(input int g, input logic [3:0] rt);
    l15_val = 1'b1;
    l15_rt  = rt;
    l15_d0  = {32'($urandom), 32'($urandom)};
    l15_d1  = {32'($urandom), 32'($urandom)};
    #1;
    chk("resp_val", resp_val_o, 1 << g);
    chk("resp_rt", resp_returntype_o, rt);
    chk("resp_d0", resp_data_0_o, l15_d0);
    chk("resp_d1", resp_data_1_o, l15_d1);
    chk("ret_no_stray", stray_o, 1'b0);
    chk("ret_ack_early", transducer_l15_req_ack, 1'b0);
    resp_ack = N'(1 << g);
    #1;
    chk("ret_consume", transducer_l15_req_ack, 1'b1);
    tick();
    l15_val  = 1'b0;
    resp_ack = '0;
  endtask

  initial begin
    int g, lat;
    logic [N-1:0] nw;
    reset_n = 1'b0;
    req_val = '0; resp_ack = '0; l15_ack = 1'b0;
    l15_val = 1'b0; l15_rt = LOAD_RET; l15_d0 = '0; l15_d1 = '0;
    for (int r = 0; r < N; r++) new_fields(r);
    last_g = N - 1;

    // Outputs held at zero under reset even with live inputs.
    req_val = 2'b11; l15_val = 1'b1; l15_rt = INT_RET; l15_ack = 1'b1;
    #2;
    chk("rst_l15_val", transducer_l15_val, 1'b0);
    chk("rst_resp_val", resp_val_o, 2'b00);
    chk("rst_req_ack", req_ack_o, 2'b00);
    chk("rst_consume", transducer_l15_req_ack, 1'b0);
    chk("rst_timeout", timeout_o, 1'b0);
    req_val = '0; l15_val = 1'b0; l15_rt = LOAD_RET; l15_ack = 1'b0;
    #20 reset_n = 1'b1;
    tick();

    // 1: single load on requester 0
    req_val = 2'b01;
    #1;
    chk("t1_idle_no_val", transducer_l15_val, 1'b0);
    grant_only(g);
    req_val = '0;
    new_fields(0);
    #1;
    chk("t1_wait_no_val", transducer_l15_val, 1'b0);
    ret(g, LOAD_RET);

    // 2: both requesting continuously alternate
    req_val = 2'b11;
    for (int i = 0; i < 4; i++) begin
      grant_only(g);
      new_fields(g);
      ret(g, ST_ACK);
    end
    req_val = '0;

    // 3: INT_RET broadcast while requester 1 owns WAIT_RESP
    req_val = 2'b10;
    grant_only(g);
    req_val = '0;
    new_fields(1);
    l15_val = 1'b1; l15_rt = INT_RET;
    #1;
    chk("t3_bcast_val", resp_val_o, 2'b11);
    resp_ack = 2'b10;
    #1;
    chk("t3_partial_ack", transducer_l15_req_ack, 1'b0);
    tick();
    resp_ack = '0;
    #1;
    chk("t3_mask_val", resp_val_o, 2'b01);
    chk("t3_hold_ack", transducer_l15_req_ack, 1'b0);
    tick();
    tick();
    resp_ack = 2'b01;
    #1;
    chk("t3_last_ack", transducer_l15_req_ack, 1'b1);
    tick();
    l15_val = 1'b0; resp_ack = '0;
    ret(g, LOAD_RET);
    l15_val = 1'b1; l15_rt = INT_RET;
    #1;
    chk("t3_mask_clear", resp_val_o, 2'b11);
    resp_ack = 2'b11;
    #1;
    chk("t3_simul_ack", transducer_l15_req_ack, 1'b1);
    tick();
    l15_val = 1'b0; resp_ack = '0;

    // 4: stray ST_ACK in IDLE
    l15_val = 1'b1; l15_rt = ST_ACK;
    #1;
    chk("t4_consume", transducer_l15_req_ack, 1'b1);
    chk("t4_no_route", resp_val_o, 2'b00);
    chk("t4_stray", stray_o, 1'b1);
    tick();
    l15_val = 1'b0;
    #1;
    chk("t4_stray_pulse", stray_o, 1'b0);

    // 5: timeout after the 16th WAIT_RESP cycle, then normal completion
    req_val = 2'b01;
    grant_only(g);
    req_val = '0;
    new_fields(0);
    repeat (T - 1) tick();
    chk("t5_before_to", timeout_o, 1'b0);
    tick();
    chk("t5_timeout", timeout_o, 1'b1);
    repeat (23) tick();
    chk("t5_sticky", timeout_o, 1'b1);
    ret(g, LOAD_RET);
    tick();
    chk("t5_sticky_after", timeout_o, 1'b1);

    // 6: asynchronous reset in SEND
    req_val = 2'b11;
    for (int n = 0; n < 8 && transducer_l15_val !== 1'b1; n++) tick();
    chk("t6_in_send", transducer_l15_val, 1'b1);
    #3 reset_n = 1'b0;
    #1;
    chk("t6_val_drop", transducer_l15_val, 1'b0);
    chk("t6_to_clear", timeout_o, 1'b0);
    last_g = N - 1;
    tick();
    tick();
    #2 reset_n = 1'b1;
    tick();
    grant_only(g);
    new_fields(g);
    ret(g, LOAD_RET);
    req_val[g] = 1'b0;

    // Random traffic against the reference model
    for (int it = 0; it < 30; it++) begin
      nw = N'($urandom_range(0, 3));
      for (int r = 0; r < N; r++) if (nw[r] && !req_val[r]) new_fields(r);
      req_val = req_val | nw;
      if (req_val == '0) begin
        new_fields(0);
        req_val = 2'b01;
      end
      grant_only(g);
      req_val[g] = 1'b0;
      lat = $urandom_range(0, 10);
      repeat (lat) tick();
      ret(g, ($urandom_range(0, 1) == 1) ? ST_ACK : LOAD_RET);
    end
    chk("rand_no_timeout", timeout_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
